dbg_host_bridge: RTL and testbench

- Host-side initiator for the core's debug command interface: cmd[7:0], addr[31:0], data[31:0] in; data[31:0] and ready out.
- Takes a byte stream from a UART receiver, assembles command frames, and drives them onto the debug module.
- Waits for the ready handshake, then returns a 5-byte response frame on a byte transmit stream.
- Sits between the board UART and the debug ports of the SoC top.

---
 rtl/dbg_host_pkg.sv | 18 +
 rtl/dbg_host_txser.sv | 52 +++++
 rtl/dbg_host_bridge.sv | 160 ++++++++++++++++
 tb/tb_dbg_host_bridge.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_host_pkg.sv
// Shared types and constants for the debug host bridge.
package dbg_host_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RX_ADDR,
      RX_DATA,
      ISSUE,
      WAIT,
      RELEASE,
      TX
   } state_e;

   localparam int unsigned FRAME_LEN    = 9;
   localparam int unsigned RESP_LEN     = 5;
   localparam logic [7:0]  DBG_CMD_IDLE = 8'h00;

endpackage

// File: rtl/dbg_host_txser.sv
// Parallel-in byte serializer for the response frame; byte 0 goes out first.
module dbg_host_txser
   import dbg_host_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    load_i,
   input  logic [8*RESP_LEN-1:0]   data_i,
   input  logic                    tx_ready_i,
   output logic                    tx_valid_o,
   output logic [7:0]              tx_data_o,
   output logic                    done_o
);

   logic [8*RESP_LEN-1:0] sr_q, sr_d;
   logic [2:0]            idx_q, idx_d;
   logic                  valid_q, valid_d;
   logic                  accept;

   assign accept     = valid_q & tx_ready_i;
   assign done_o     = accept && (idx_q == 3'(RESP_LEN - 1));
   assign tx_valid_o = valid_q;
   assign tx_data_o  = sr_q[7:0];

   always_comb begin
      sr_d    = sr_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      if (load_i) begin
         sr_d    = data_i;
         idx_d   = 3'd0;
         valid_d = 1'b1;
      end else if (accept) begin
         sr_d  = {8'h00, sr_q[8*RESP_LEN-1:8]};
         idx_d = idx_q + 3'd1;
         if (done_o) valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sr_q    <= '0;
         idx_q   <= 3'd0;
         valid_q <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/dbg_host_bridge.sv
// UART-to-debug-port bridge: assembles 9-byte request frames, issues them, returns a 5-byte response.
// state   | meaning
// IDLE    | waiting for a nonzero command byte (00 is a sync byte)
// RX_ADDR | shifting in address bytes, LSB first
// RX_DATA | shifting in write-data bytes, LSB first
// ISSUE   | address/data already driven, raise command
// WAIT    | command held until ready or timeout
// RELEASE | command dropped, waiting for ready to fall
// TX      | response frame owned by the serializer
module dbg_host_bridge
   import dbg_host_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC  = 65536,
   parameter int unsigned FRAME_TO_CYC = 1000000,
   parameter logic [7:0]  STATUS_OK    = 8'hA5,
   parameter logic [7:0]  STATUS_TO    = 8'hEE
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   output logic        tx_valid_o,
   output logic [7:0]  tx_data_o,
   input  logic        tx_ready_i,
   output logic [7:0]  dbg_cmd_o,
   output logic [31:0] dbg_addr_o,
   output logic [31:0] dbg_data_o,
   input  logic [31:0] dbg_data_i,
   input  logic        dbg_ready_i,
   output logic        busy_o,
   output logic        overrun_o
);

   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int FTO_W = $clog2(FRAME_TO_CYC + 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [FTO_W-1:0] FTO_LAST = FTO_W'(FRAME_TO_CYC - 1);

   state_e            state_q;
   logic [7:0]        cmd_q;
   logic [31:0]       addr_sr_q, data_sr_q;
   logic [3:0]        idx_q;
   logic [FTO_W-1:0]  fto_cnt_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic [7:0]        status_q;
   logic [31:0]       rdata_q;
   logic [7:0]        dbg_cmd_q;
   logic [31:0]       dbg_addr_q, dbg_data_q;
   logic              overrun_q;
   logic              rel_done, tx_done;

   // Serializer is loaded on the RELEASE exit edge so the first byte is valid one cycle later.
   assign rel_done = (state_q == RELEASE) && (!dbg_ready_i || (to_cnt_q >= TO_LAST));

   assign dbg_cmd_o  = dbg_cmd_q;
   assign dbg_addr_o = dbg_addr_q;
   assign dbg_data_o = dbg_data_q;
   assign busy_o     = (state_q != IDLE);
   assign overrun_o  = overrun_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cmd_q      <= 8'h00;
         addr_sr_q  <= 32'h0;
         data_sr_q  <= 32'h0;
         idx_q      <= 4'd0;
         fto_cnt_q  <= '0;
         to_cnt_q   <= '0;
         status_q   <= 8'h00;
         rdata_q    <= 32'h0;
         dbg_cmd_q  <= DBG_CMD_IDLE;
         dbg_addr_q <= 32'h0;
         dbg_data_q <= 32'h0;
         overrun_q  <= 1'b0;
      end else begin
         overrun_q <= rx_valid_i && (state_q inside {ISSUE, WAIT, RELEASE, TX});
         case (state_q)
            IDLE: begin
               if (rx_valid_i && (rx_data_i != DBG_CMD_IDLE)) begin
                  cmd_q     <= rx_data_i;
                  idx_q     <= 4'd1;
                  fto_cnt_q <= '0;
                  state_q   <= RX_ADDR;
               end
            end
            RX_ADDR: begin
               if (rx_valid_i) begin
                  addr_sr_q <= {rx_data_i, addr_sr_q[31:8]};
                  idx_q     <= idx_q + 4'd1;
                  fto_cnt_q <= '0;
                  if (idx_q == 4'd4) state_q <= RX_DATA;
               end else if (fto_cnt_q >= FTO_LAST) begin
                  state_q <= IDLE;
               end else begin
                  fto_cnt_q <= fto_cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_valid_i) begin
                  data_sr_q <= {rx_data_i, data_sr_q[31:8]};
                  idx_q     <= idx_q + 4'd1;
                  fto_cnt_q <= '0;
                  if (idx_q == 4'(FRAME_LEN - 1)) begin
                     dbg_addr_q <= addr_sr_q;
                     dbg_data_q <= {rx_data_i, data_sr_q[31:8]};
                     state_q    <= ISSUE;
                  end
               end else if (fto_cnt_q >= FTO_LAST) begin
                  state_q <= IDLE;
               end else begin
                  fto_cnt_q <= fto_cnt_q + 1'b1;
               end
            end
            ISSUE: begin
               dbg_cmd_q <= cmd_q;
               to_cnt_q  <= '0;
               state_q   <= WAIT;
            end
            WAIT: begin
               if (dbg_ready_i) begin
                  rdata_q   <= dbg_data_i;
                  status_q  <= STATUS_OK;
                  dbg_cmd_q <= DBG_CMD_IDLE;
                  to_cnt_q  <= '0;
                  state_q   <= RELEASE;
               end else if (to_cnt_q >= TO_LAST) begin
                  rdata_q   <= 32'h0;
                  status_q  <= STATUS_TO;
                  dbg_cmd_q <= DBG_CMD_IDLE;
                  to_cnt_q  <= '0;
                  state_q   <= RELEASE;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            RELEASE: begin
               if (rel_done) state_q  <= TX;
               else          to_cnt_q <= to_cnt_q + 1'b1;
            end
            TX: begin
               if (tx_done) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   dbg_host_txser u_txser (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (rel_done),
      .data_i     ({rdata_q, status_q}),
      .tx_ready_i (tx_ready_i),
      .tx_valid_o (tx_valid_o),
      .tx_data_o  (tx_data_o),
      .done_o     (tx_done)
   );

endmodule

// File: tb/tb_dbg_host_bridge.sv
// Randomized self-checking bench for dbg_host_bridge against a transaction-level expectation model.
module tb_dbg_host_bridge;

   localparam int TO  = 16;
   localparam int FTO = 40;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        rx_valid_i;
   logic [7:0]  rx_data_i;
   logic        tx_valid_o;
   logic [7:0]  tx_data_o;
   logic        tx_ready_i;
   logic [7:0]  dbg_cmd_o;
   logic [31:0] dbg_addr_o;
   logic [31:0] dbg_data_o;
   logic [31:0] dbg_data_i;
   logic        dbg_ready_i;
   logic        busy_o;
   logic        overrun_o;

   int n_tests = 0;
   int n_fail  = 0;
   int ovr_cnt = 0;

   always #5 clk_i = ~clk_i;

   dbg_host_bridge #(
      .TIMEOUT_CYC  (TO),
      .FRAME_TO_CYC (FTO),
      .STATUS_OK    (8'hA5),
      .STATUS_TO    (8'hEE)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rx_valid_i  (rx_valid_i),
      .rx_data_i   (rx_data_i),
      .tx_valid_o  (tx_valid_o),
      .tx_data_o   (tx_data_o),
      .tx_ready_i  (tx_ready_i),
      .dbg_cmd_o   (dbg_cmd_o),
      .dbg_addr_o  (dbg_addr_o),
      .dbg_data_o  (dbg_data_o),
      .dbg_data_i  (dbg_data_i),
      .dbg_ready_i (dbg_ready_i),
      .busy_o      (busy_o),
      .overrun_o   (overrun_o)
   );

   task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      if (overrun_o) ovr_cnt++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      step();
      rx_valid_i = 1'b0;
      rx_data_i  = 8'($urandom);
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                             input int n_sync, input int gap1);
      logic [7:0] fr [9];
      fr[0] = cmd;
      for (int i = 0; i < 4; i++) begin
         fr[1+i] = 8'((addr >> (8*i)) & 32'hFF);
         fr[5+i] = 8'((data >> (8*i)) & 32'hFF);
      end
      for (int i = 0; i < n_sync; i++) begin
         send_byte(8'h00);
         idle($urandom_range(0, 2));
      end
      for (int i = 0; i < 9; i++) begin
         send_byte(fr[i]);
         if (i < 8) idle((i == 1) ? gap1 : $urandom_range(0, 2));
      end
   endtask

   task automatic wait_cmd(output int n);
      n = 1;
      while (dbg_cmd_o == 8'h00 && n < 20) begin
         step();
         n++;
      end
   endtask

   // lat: WAIT-cycle index at which ready rises (>= TO means never); rel_hold: cycles ready stays high.
   task automatic run_txn(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rd, input int n_sync, input int gap1, input int lat,
                          input int rel_hold, input int bp, input bit extra);
      bit         ok;
      logic [7:0] exp_b [5];
      logic [7:0] got_b [5];
      int         ovr0, n, k, cmd_len, txv_k, exp_txv, got, c, wcnt, extra_tx;
      bit         hold_bad, unstable, gap_bad, pv, pacc, acc;
      logic [7:0] pd;

      ok = (lat < TO);
      exp_b[0] = ok ? 8'hA5 : 8'hEE;
      for (int i = 0; i < 4; i++) exp_b[1+i] = ok ? 8'((rd >> (8*i)) & 32'hFF) : 8'h00;
      exp_txv = ok ? lat + 2 + ((rel_hold - 1 < TO - 1) ? rel_hold - 1 : TO - 1) : TO + 1;
      ovr0 = ovr_cnt;

      send_frame(cmd, addr, data, n_sync, gap1);
      check_eq("pre_cmd_idle", dbg_cmd_o, 8'h00);
      check_eq("addr_early", dbg_addr_o, addr);
      check_eq("data_early", dbg_data_o, data);
      check_eq("busy_issue", busy_o, 1'b1);
      wait_cmd(n);
      check_eq("cmd_latency", n, 2);
      check_eq("cmd", dbg_cmd_o, cmd);
      check_eq("addr", dbg_addr_o, addr);
      check_eq("data", dbg_data_o, data);

      k = 0; cmd_len = -1; txv_k = -1; hold_bad = 0;
      while (k < 4*TO + 40) begin
         if (tx_valid_o) begin
            txv_k = k;
            break;
         end
         if (dbg_cmd_o == 8'h00 && cmd_len < 0) cmd_len = k;
         if (cmd_len < 0 && (dbg_cmd_o !== cmd || dbg_addr_o !== addr || dbg_data_o !== data))
            hold_bad = 1;
         dbg_ready_i = ok && (k >= lat) && (k < lat + rel_hold);
         dbg_data_i  = dbg_ready_i ? rd : $urandom;
         if (extra && k == 1) begin
            rx_valid_i = 1'b1;
            rx_data_i  = 8'($urandom);
         end
         step();
         rx_valid_i = 1'b0;
         k++;
      end
      dbg_ready_i = 1'b0;
      check_eq("wait_hold", hold_bad, 1'b0);
      check_eq("cmd_len", cmd_len, ok ? lat + 1 : TO);
      check_eq("tx_start", txv_k, exp_txv);

      got = 0; c = 0; wcnt = 0; unstable = 0; gap_bad = 0; pv = 0; pacc = 0; pd = 8'h00;
      while (got < 5 && c < 400) begin
         if (pv && !pacc && (!tx_valid_o || tx_data_o !== pd)) unstable = 1;
         if (pacc && !tx_valid_o) gap_bad = 1;
         tx_ready_i = (bp > 0) ? (wcnt >= bp) : 1'($urandom_range(0, 1));
         acc = tx_valid_o && tx_ready_i;
         if (acc) begin
            got_b[got] = tx_data_o;
            got++;
            wcnt = 0;
         end else if (tx_valid_o) begin
            wcnt++;
         end
         pv = tx_valid_o; pd = tx_data_o; pacc = acc && (got < 5);
         step();
         c++;
      end
      check_eq("tx_count", got, 5);
      check_eq("tx_stable", unstable, 1'b0);
      check_eq("tx_gap", gap_bad, 1'b0);
      check_eq("tx_valid_fall", tx_valid_o, 1'b0);
      check_eq("busy_done", busy_o, 1'b0);
      for (int i = 0; i < 5; i++) check_eq($sformatf("tx_byte%0d", i), got_b[i], exp_b[i]);

      tx_ready_i = 1'b1;
      extra_tx = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (tx_valid_o) extra_tx++;
      end
      tx_ready_i = 1'b0;
      check_eq("tx_extra", extra_tx, 0);
      check_eq("overrun_cnt", ovr_cnt - ovr0, extra ? 1 : 0);
   endtask

   initial begin
      int n;
      rst_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00; tx_ready_i = 1'b0;
      dbg_data_i = 32'h0; dbg_ready_i = 1'b0;
      idle(3);
      check_eq("rst_cmd", dbg_cmd_o, 8'h00);
      check_eq("rst_addr", dbg_addr_o, 32'h0);
      check_eq("rst_data", dbg_data_o, 32'h0);
      check_eq("rst_txv", tx_valid_o, 1'b0);
      check_eq("rst_txd", tx_data_o, 8'h00);
      check_eq("rst_busy", busy_o, 1'b0);
      check_eq("rst_ovr", overrun_o, 1'b0);
      rst_i = 1'b0;
      idle(2);

      // basic
      run_txn(8'h01, 32'h00000010, 32'hDEADBEEF, 32'h12345678, 0, 0, 3, 1, 1, 0);
      // backpressure
      run_txn(8'h05, 32'hA0B0C0D0, 32'h01020304, 32'h89ABCDEF, 0, 1, 2, 2, 7, 0);
      // debug timeout
      run_txn(8'h07, 32'h11223344, 32'h55667788, 32'hFFFFFFFF, 0, 0, 1000, 1, 1, 0);

      // partial frame discarded after FTO idle cycles
      send_byte(8'h02);
      idle(1);
      send_byte(8'h34);
      idle(FTO);
      check_eq("partial_busy", busy_o, 1'b0);
      check_eq("partial_cmd", dbg_cmd_o, 8'h00);
      check_eq("partial_txv", tx_valid_o, 1'b0);
      run_txn(8'h02, 32'h00003434, 32'h9ABC0000, 32'h0F0F0F0F, 0, 2, 4, 2, 0, 0);

      // sync zeros and overrun
      run_txn(8'h44, 32'h76543210, 32'hFEDCBA98, 32'hC001D00D, 2, 1, 5, 1, 0, 1);

      // gap one cycle short of the frame timeout keeps the frame
      run_txn(8'h21, 32'h0000BEEF, 32'h00000001, 32'h00000002, 0, FTO - 1, 0, 1, 0, 0);
      // ready already high on WAIT entry, and a long ready hold that hits the release timeout
      run_txn(8'h22, 32'h1, 32'h2, 32'hA1B2C3D4, 0, 0, 0, 1, 1, 0);
      run_txn(8'h23, 32'h3, 32'h4, 32'h5566AA77, 0, 0, 2, TO + 5, 0, 0);

      // reset while in WAIT
      send_frame(8'h03, 32'hCAFE0004, 32'h0BADF00D, 0, 1);
      wait_cmd(n);
      check_eq("rstw_cmd_pre", dbg_cmd_o, 8'h03);
      idle(4);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      check_eq("rstw_cmd", dbg_cmd_o, 8'h00);
      check_eq("rstw_busy", busy_o, 1'b0);
      check_eq("rstw_txv", tx_valid_o, 1'b0);
      idle(2);
      run_txn(8'h03, 32'hCAFE0008, 32'h12121212, 32'h34343434, 0, 0, 1, 1, 0, 0);

      for (int t = 0; t < 25; t++) begin
         run_txn(8'($urandom_range(1, 255)), $urandom, $urandom, $urandom,
                 $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, TO + 3),
                 $urandom_range(1, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog expired");
   end

endmodule
